// File: rtl/axi_line_bridge.sv
// axi_line_bridge
//
// Single-port AXI4 master that moves whole cache lines for three clients:
// the icache refill path, the dcache refill path and the dcache write-back
// path. One INCR burst of 32-bit beats is in flight at a time. Read beats
// are shifted into a line buffer, and a victim line is shifted out of a
// separate write buffer.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   i_rreq/i_raddr           : icache refill request and address
//   i_rdone/i_rline          : icache completion pulse and refilled line
//   d_rreq/d_raddr           : dcache refill request and address
//   d_rdone/d_rline          : dcache refill completion pulse and line
//   d_wreq/d_waddr/d_wline   : dcache write-back request, address and line
//   d_wdone                  : dcache write-back completion pulse
//   ar*/r*/aw*/w*/b*         : AXI4 master channels (32-bit data)
//   axi_err                  : sticky error flag, cleared only by reset
//
// Every output is decoded from registered state only.

module axi_line_bridge #(
  parameter int LINE_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_rreq,
  input  logic [31:0]           i_raddr,
  output logic                  i_rdone,
  output logic [LINE_WIDTH-1:0] i_rline,

  input  logic                  d_rreq,
  input  logic [31:0]           d_raddr,
  output logic                  d_rdone,
  output logic [LINE_WIDTH-1:0] d_rline,

  input  logic                  d_wreq,
  input  logic [31:0]           d_waddr,
  input  logic [LINE_WIDTH-1:0] d_wline,
  output logic                  d_wdone,

  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,

  input  logic [31:0]           rdata,
  input  logic                  rlast,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,

  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,

  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,

  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,

  output logic                  axi_err
);

  localparam int BEATS = LINE_WIDTH / 32;
  localparam int OFFS  = $clog2(LINE_WIDTH / 8);
  localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);
  localparam logic [31:0] ADDR_MASK = {{(32 - OFFS){1'b1}}, {OFFS{1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [1:0] OWN_IW = 2'd0;
  localparam logic [1:0] OWN_DR = 2'd1;
  localparam logic [1:0] OWN_DW = 2'd2;

  logic [2:0]            state;
  logic [1:0]            owner;
  logic [31:0]           addr;
  logic [LINE_WIDTH-1:0] rbuf;
  logic [LINE_WIDTH-1:0] wbuf;
  logic [7:0]            cnt;
  logic                  err;

  // Main sequencer. Arbitration only happens in IDLE, so a request that
  // changes or drops mid-transfer has no effect: address and victim line
  // were captured at grant. The write-back wins over both refills so the
  // victim reaches memory before any refill can read that line back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= OWN_IW;
      addr  <= '0;
      rbuf  <= '0;
      wbuf  <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (d_wreq) begin
            owner <= OWN_DW;
            addr  <= d_waddr & ADDR_MASK;
            wbuf  <= d_wline;
            rbuf  <= '0;
            cnt   <= '0;
            state <= S_AW;
          end else if (d_rreq) begin
            owner <= OWN_DR;
            addr  <= d_raddr & ADDR_MASK;
            rbuf  <= '0;
            cnt   <= '0;
            state <= S_AR;
          end else if (i_rreq) begin
            owner <= OWN_IW;
            addr  <= i_raddr & ADDR_MASK;
            rbuf  <= '0;
            cnt   <= '0;
            state <= S_AR;
          end
        end

        S_AR: begin
          if (arready) state <= S_R;
        end

        // rready is high for the whole of this state, so rvalid alone marks
        // an accepted beat. New beats enter at the top so that beat 0 has
        // drifted down to bits [31:0] once the burst is complete. A short or
        // long burst, or a bad response, is flagged but still ends at rlast.
        S_R: begin
          if (rvalid) begin
            rbuf <= {rdata, rbuf[LINE_WIDTH-1:32]};
            cnt  <= cnt + 8'd1;
            if ((rresp != 2'b00) || (rlast && (cnt != LAST_BEAT))) err <= 1'b1;
            if (rlast) state <= S_DONE;
          end
        end

        S_AW: begin
          if (awready) state <= S_W;
        end

        // The low word of the write buffer is always the beat on the bus;
        // it only advances when the slave takes it.
        S_W: begin
          if (wready) begin
            wbuf <= {32'h0, wbuf[LINE_WIDTH-1:32]};
            cnt  <= cnt + 8'd1;
            if (cnt == LAST_BEAT) state <= S_B;
          end
        end

        S_B: begin
          if (bvalid) begin
            if (bresp != 2'b00) err <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign araddr  = addr;
  assign arlen   = LAST_BEAT;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R);

  assign awaddr  = addr;
  assign awlen   = LAST_BEAT;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awvalid = (state == S_AW);

  assign wdata   = wbuf[31:0];
  assign wstrb   = 4'hF;
  assign wvalid  = (state == S_W);
  assign wlast   = (state == S_W) && (cnt == LAST_BEAT);
  assign bready  = (state == S_B);

  assign i_rdone = (state == S_DONE) && (owner == OWN_IW);
  assign d_rdone = (state == S_DONE) && (owner == OWN_DR);
  assign d_wdone = (state == S_DONE) && (owner == OWN_DW);
  assign i_rline = rbuf;
  assign d_rline = rbuf;

  assign axi_err = err;

endmodule

// File: tb/tb_axi_line_bridge.sv
// tb_axi_line_bridge
//
// Drives axi_line_bridge with a 512-bit line. A memory-backed AXI slave
// sits on the bus side with configurable address delays and data gaps.
// Expected lines come from a golden word memory that is updated with
// every write-back the bench issues.

module tb_axi_line_bridge;

  localparam int LW    = 512;
  localparam int BEATS = LW / 32;
  localparam int MEMW  = 1024;
  localparam int LINES = MEMW / BEATS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          i_rreq = 1'b0;
  logic [31:0]   i_raddr = '0;
  logic          i_rdone;
  logic [LW-1:0] i_rline;
  logic          d_rreq = 1'b0;
  logic [31:0]   d_raddr = '0;
  logic          d_rdone;
  logic [LW-1:0] d_rline;
  logic          d_wreq = 1'b0;
  logic [31:0]   d_waddr = '0;
  logic [LW-1:0] d_wline = '0;
  logic          d_wdone;

  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        axi_err;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Slave memory (written by the DUT) and the golden reference memory.
  logic [31:0] mem  [MEMW];
  logic [31:0] gold [MEMW];

  // Slave configuration and bookkeeping.
  int  dly_max = 0;
  bit  rgap_on = 1'b0;
  bit  wgap_on = 1'b0;
  int  short_len = 0;
  logic [1:0] bresp_val = 2'b00;
  bit  rd_phase = 1'b0, wr_phase = 1'b0, b_phase = 1'b0;
  int  rd_word = 0, rd_beat = 0, rd_total = 0;
  int  wr_word = 0, wr_beat = 0;
  int  ar_wait = 0, aw_wait = 0;
  int  strb_bad = 0;
  logic [31:0] cap_araddr = '0, cap_awaddr = '0;
  logic [7:0]  cap_arlen = '0, cap_awlen = '0;
  logic [2:0]  cap_arsize = '0, cap_awsize = '0;
  logic [1:0]  cap_arburst = '0, cap_awburst = '0;
  logic [31:0] wq[$];
  bit          lq[$];

  axi_line_bridge #(.LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_rreq(i_rreq), .i_raddr(i_raddr), .i_rdone(i_rdone), .i_rline(i_rline),
    .d_rreq(d_rreq), .d_raddr(d_raddr), .d_rdone(d_rdone), .d_rline(d_rline),
    .d_wreq(d_wreq), .d_waddr(d_waddr), .d_wline(d_wline), .d_wdone(d_wdone),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .axi_err(axi_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference helpers: a line lives at word (line index mod LINES) * BEATS.
  function automatic int line_base(input logic [31:0] a);
    int unsigned la;
    la = a / (LW / 8);
    return int'(la % LINES) * BEATS;
  endfunction

  function automatic logic [LW-1:0] exp_line(input logic [31:0] a);
    logic [LW-1:0] l;
    int b;
    b = line_base(a);
    for (int k = 0; k < BEATS; k++) l[32*k +: 32] = gold[b + k];
    return l;
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [31:0] a);
    logic [LW-1:0] l;
    int b;
    b = line_base(a);
    for (int k = 0; k < BEATS; k++) l[32*k +: 32] = mem[b + k];
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < BEATS; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  task automatic gold_write(input logic [31:0] a, input logic [LW-1:0] l);
    int b;
    b = line_base(a);
    for (int k = 0; k < BEATS; k++) gold[b + k] = l[32*k +: 32];
  endtask

  function automatic logic done_of(input int kind);
    return (kind == 0) ? i_rdone : (kind == 1) ? d_rdone : d_wdone;
  endfunction

  task automatic set_req(input int kind, input logic v);
    if (kind == 0) i_rreq = v;
    else if (kind == 1) d_rreq = v;
    else d_wreq = v;
  endtask

  // AXI slave, acting on the falling edge. DUT outputs are stable until the
  // next rising edge, so valid&ready decided here is the handshake that the
  // DUT will see at that edge.
  initial begin : slave
    for (int k = 0; k < MEMW; k++) begin
      mem[k]  = $urandom;
      gold[k] = mem[k];
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rd_phase = 1'b0; wr_phase = 1'b0; b_phase = 1'b0;
        ar_wait = 0; aw_wait = 0;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        if (rd_phase) begin
          if (!(rgap_on && $urandom_range(0, 2) == 0)) begin
            rvalid = 1'b1;
            rdata  = mem[(rd_word + rd_beat) % MEMW];
            rlast  = (rd_beat == rd_total - 1);
            rresp  = 2'b00;
          end
          if (rvalid && rready) begin
            rd_beat++;
            if (rlast) rd_phase = 1'b0;
          end
        end
        arready = 1'b0;
        if (arvalid && !rd_phase) begin
          if (ar_wait > 0) ar_wait--;
          else begin
            arready     = 1'b1;
            cap_araddr  = araddr;
            cap_arlen   = arlen;
            cap_arsize  = arsize;
            cap_arburst = arburst;
            rd_word  = int'(araddr[11:2]);
            rd_beat  = 0;
            rd_total = (short_len > 0) ? short_len : BEATS;
            rd_phase = 1'b1;
            ar_wait  = $urandom_range(0, dly_max);
          end
        end
        bvalid = 1'b0;
        if (b_phase) begin
          bvalid = 1'b1;
          bresp  = bresp_val;
          if (bready) b_phase = 1'b0;
        end
        wready = 1'b0;
        if (wr_phase) begin
          wready = !(wgap_on && $urandom_range(0, 2) == 0);
          if (wready && wvalid) begin
            mem[(wr_word + wr_beat) % MEMW] = wdata;
            wq.push_back(wdata);
            lq.push_back(wlast);
            if (wstrb !== 4'hF) strb_bad++;
            wr_beat++;
            if (wr_beat == BEATS) begin
              wr_phase = 1'b0;
              b_phase  = 1'b1;
            end
          end
        end
        awready = 1'b0;
        if (awvalid && !wr_phase && !b_phase) begin
          if (aw_wait > 0) aw_wait--;
          else begin
            awready     = 1'b1;
            cap_awaddr  = awaddr;
            cap_awlen   = awlen;
            cap_awsize  = awsize;
            cap_awburst = awburst;
            wr_word  = int'(awaddr[11:2]);
            wr_beat  = 0;
            wr_phase = 1'b1;
            aw_wait  = $urandom_range(0, dly_max);
          end
        end
      end
    end
  end

  // Issue one request, wait (bounded) for its done pulse, drop the request
  // there and measure how many cycles the pulse stays high.
  task automatic run_xfer(input int kind, input logic [31:0] a, input logic [LW-1:0] wl,
                          output int lat, output logic [LW-1:0] line,
                          output bit timed_out, output int pulse_len);
    int start;
    @(negedge clk);
    if (kind == 0) i_raddr = a;
    else if (kind == 1) d_raddr = a;
    else begin
      d_waddr = a;
      d_wline = wl;
    end
    set_req(kind, 1'b1);
    start = cyc;
    timed_out = 1'b1;
    lat = 0;
    line = '0;
    pulse_len = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done_of(kind)) begin
        lat = cyc - start;
        line = (kind == 0) ? i_rline : d_rline;
        timed_out = 1'b0;
        break;
      end
    end
    set_req(kind, 1'b0);
    if (!timed_out) begin
      pulse_len = 1;
      for (int n = 0; n < 4; n++) begin
        @(negedge clk);
        if (done_of(kind)) pulse_len++;
        else break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({arvalid, rready, awvalid, wvalid, wlast, bready} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_handshakes: got %b expected 000000",
               {arvalid, rready, awvalid, wvalid, wlast, bready});
    end
    checks++;
    if ({i_rdone, d_rdone, d_wdone} !== 3'b0) begin
      fails++;
      $display("[TB] FAIL reset_done: got %b expected 000", {i_rdone, d_rdone, d_wdone});
    end
    checks++;
    if (axi_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_err: got %b expected 0", axi_err);
    end
    checks++;
    if (araddr !== 32'h0 || awaddr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_addr: got %h/%h expected 0/0", araddr, awaddr);
    end
    checks++;
    if (i_rline !== '0 || d_rline !== '0) begin
      fails++;
      $display("[TB] FAIL reset_line: got %h expected 0", i_rline);
    end
    rst = 1'b0;
  endtask

  task automatic test_icache_refill();
    logic [31:0] a;
    logic [LW-1:0] line, exp;
    int lat, pl, b;
    bit to;
    a = $urandom;
    b = line_base(a);
    for (int k = 0; k < BEATS; k++) begin
      mem[b + k]  = k;
      gold[b + k] = k;
    end
    exp = exp_line(a);
    run_xfer(0, a, '0, lat, line, to, pl);
    checks++;
    if (to || lat != BEATS + 2) begin
      fails++;
      $display("[TB] FAIL icache_latency: got %0d (timeout %0b) expected %0d", lat, to, BEATS + 2);
    end
    checks++;
    if (line[31:0] !== 32'd0 || line[LW-1:LW-32] !== 32'(BEATS - 1)) begin
      fails++;
      $display("[TB] FAIL icache_end_words: got %h/%h expected 0/%h",
               line[31:0], line[LW-1:LW-32], BEATS - 1);
    end
    checks++;
    if (line !== exp) begin
      fails++;
      $display("[TB] FAIL icache_line: got %h expected %h", line, exp);
    end
    checks++;
    if (cap_araddr !== (a & ~32'h3F)) begin
      fails++;
      $display("[TB] FAIL icache_araddr: got %h expected %h", cap_araddr, a & ~32'h3F);
    end
    checks++;
    if (cap_arlen !== 8'(BEATS - 1) || cap_arsize !== 3'b010 || cap_arburst !== 2'b01) begin
      fails++;
      $display("[TB] FAIL icache_burst: got len %0d size %0d burst %0d expected %0d 2 1",
               cap_arlen, cap_arsize, cap_arburst, BEATS - 1);
    end
  endtask

  task automatic test_writeback();
    logic [31:0] a;
    logic [LW-1:0] wl, line;
    int lat, pl;
    bit to;
    a = $urandom;
    for (int k = 0; k < BEATS; k++) wl[32*k +: 32] = k;
    gold_write(a, wl);
    wq.delete();
    lq.delete();
    strb_bad = 0;
    run_xfer(2, a, wl, lat, line, to, pl);
    checks++;
    if (to || lat != BEATS + 3) begin
      fails++;
      $display("[TB] FAIL wb_latency: got %0d (timeout %0b) expected %0d", lat, to, BEATS + 3);
    end
    checks++;
    if (wq.size() != BEATS) begin
      fails++;
      $display("[TB] FAIL wb_beat_count: got %0d expected %0d", wq.size(), BEATS);
    end
    for (int k = 0; k < BEATS && k < wq.size(); k++) begin
      checks++;
      if (wq[k] !== 32'(k) || lq[k] !== (k == BEATS - 1)) begin
        fails++;
        $display("[TB] FAIL wb_beat%0d: got data %h last %b expected %h %b",
                 k, wq[k], lq[k], k, k == BEATS - 1);
      end
    end
    checks++;
    if (cap_awaddr !== (a & ~32'h3F) || cap_awlen !== 8'(BEATS - 1) ||
        cap_awsize !== 3'b010 || cap_awburst !== 2'b01 || strb_bad != 0) begin
      fails++;
      $display("[TB] FAIL wb_aw_fields: got addr %h len %0d size %0d burst %0d badstrb %0d expected %h %0d 2 1 0",
               cap_awaddr, cap_awlen, cap_awsize, cap_awburst, strb_bad, a & ~32'h3F, BEATS - 1);
    end
    checks++;
    if (mem_line(a) !== wl) begin
      fails++;
      $display("[TB] FAIL wb_memory: got %h expected %h", mem_line(a), wl);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] aw, ar, ai;
    logic [LW-1:0] wl, exp_d, exp_i, got_d, got_i;
    int ord[3], tm[3], exp_ord[3], exp_tm[3];
    int n, t0;
    exp_ord = '{2, 1, 0};
    exp_tm  = '{BEATS + 3, 2 * BEATS + 6, 3 * BEATS + 9};
    ord = '{-1, -1, -1};
    tm  = '{0, 0, 0};
    n = 0;
    got_d = '0;
    got_i = '0;
    aw = $urandom;
    ar = $urandom;
    ai = $urandom;
    wl = rand_line();
    gold_write(aw, wl);
    exp_d = exp_line(ar);
    exp_i = exp_line(ai);
    @(negedge clk);
    d_waddr = aw; d_wline = wl; d_raddr = ar; i_raddr = ai;
    d_wreq = 1'b1; d_rreq = 1'b1; i_rreq = 1'b1;
    t0 = cyc;
    for (int c = 0; c < 400 && n < 3; c++) begin
      @(negedge clk);
      if (d_wdone && n < 3) begin ord[n] = 2; tm[n] = cyc - t0; n++; d_wreq = 1'b0; end
      if (d_rdone && n < 3) begin ord[n] = 1; tm[n] = cyc - t0; got_d = d_rline; n++; d_rreq = 1'b0; end
      if (i_rdone && n < 3) begin ord[n] = 0; tm[n] = cyc - t0; got_i = i_rline; n++; i_rreq = 1'b0; end
    end
    d_wreq = 1'b0; d_rreq = 1'b0; i_rreq = 1'b0;
    checks++;
    if (n != 3) begin
      fails++;
      $display("[TB] FAIL simul_completions: got %0d expected 3", n);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ord[k] != exp_ord[k] || tm[k] != exp_tm[k]) begin
        fails++;
        $display("[TB] FAIL simul_grant%0d: got id %0d at %0d expected id %0d at %0d",
                 k, ord[k], tm[k], exp_ord[k], exp_tm[k]);
      end
    end
    checks++;
    if (got_d !== exp_d || got_i !== exp_i) begin
      fails++;
      $display("[TB] FAIL simul_lines: got %h expected %h", got_d, exp_d);
    end
    @(negedge clk);
  endtask

  task automatic test_random_waits();
    int kind, lat, pl;
    logic [31:0] a;
    logic [LW-1:0] wl, line, exp;
    bit to;
    dly_max = 5;
    rgap_on = 1'b1;
    wgap_on = 1'b1;
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      wl = rand_line();
      if (kind == 2) gold_write(a, wl);
      exp = exp_line(a);
      run_xfer(kind, a, wl, lat, line, to, pl);
      checks++;
      if (to || pl != 1) begin
        fails++;
        $display("[TB] FAIL rand%0d_pulse: got width %0d (timeout %0b) expected 1", it, pl, to);
      end
      checks++;
      if (kind == 2) begin
        if (mem_line(a) !== wl) begin
          fails++;
          $display("[TB] FAIL rand%0d_wb_memory: got %h expected %h", it, mem_line(a), wl);
        end
      end else if (line !== exp) begin
        fails++;
        $display("[TB] FAIL rand%0d_refill_line: got %h expected %h", it, line, exp);
      end
    end
    dly_max = 0;
    rgap_on = 1'b0;
    wgap_on = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] a;
    logic [LW-1:0] line, exp;
    int lat, pl, b;
    bit to;
    do_reset();
    checks++;
    if (axi_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL err_cleared: got %b expected 0", axi_err);
    end
    a = $urandom;
    b = line_base(a);
    exp = '0;
    for (int k = 0; k < 4; k++) exp[LW - 32 * (4 - k) +: 32] = gold[b + k];
    short_len = 4;
    run_xfer(1, a, '0, lat, line, to, pl);
    short_len = 0;
    checks++;
    if (to || lat != 6) begin
      fails++;
      $display("[TB] FAIL short_rlast_latency: got %0d (timeout %0b) expected 6", lat, to);
    end
    checks++;
    if (axi_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL short_rlast_err: got %b expected 1", axi_err);
    end
    checks++;
    if (line !== exp) begin
      fails++;
      $display("[TB] FAIL short_rlast_line: got %h expected %h", line, exp);
    end
    do_reset();
    a = $urandom;
    line = rand_line();
    gold_write(a, line);
    bresp_val = 2'b10;
    run_xfer(2, a, line, lat, exp, to, pl);
    bresp_val = 2'b00;
    checks++;
    if (to || lat != BEATS + 3 || axi_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bresp_err: got lat %0d err %b (timeout %0b) expected %0d 1",
               lat, axi_err, to, BEATS + 3);
    end
    do_reset();
  endtask

  task automatic test_reset_midburst();
    logic [31:0] a;
    logic [LW-1:0] line, exp;
    int lat, pl;
    bit to, hit;
    hit = 1'b0;
    @(negedge clk);
    i_raddr = $urandom;
    i_rreq = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (rd_phase && rd_beat == 8) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      fails++;
      $display("[TB] FAIL midburst_reach_beat7: got no beat 7 expected beat 7 within bound");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, wlast, bready, i_rdone, d_rdone, d_wdone, axi_err} !== 10'b0 ||
        araddr !== 32'h0 || i_rline !== '0) begin
      fails++;
      $display("[TB] FAIL midburst_async_reset: got ctl %b addr %h expected 0 0",
               {arvalid, rready, awvalid, wvalid, wlast, bready, i_rdone, d_rdone, d_wdone, axi_err}, araddr);
    end
    @(negedge clk);
    i_rreq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    a = $urandom;
    exp = exp_line(a);
    run_xfer(0, a, '0, lat, line, to, pl);
    checks++;
    if (to || lat != BEATS + 2 || line !== exp) begin
      fails++;
      $display("[TB] FAIL after_reset_refill: got lat %0d line %h expected %0d %h", lat, line, BEATS + 2, exp);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    test_reset();
    test_icache_refill();
    test_writeback();
    test_simultaneous();
    test_random_waits();
    test_errors();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
